// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package prog_loader_pkg;

    localparam int BYTE_W             = 8;
    localparam int LEN_ZERO_MEANS_MAX = 256;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_DATA = 3'd2,
        ST_CSUM = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } state_t;

endpackage

// File: rtl/prog_loader.sv
// Framed byte-stream loader into instruction memory; holds the core until a good load.
// Optional trailing checksum byte enabled by defining PROG_LOADER_CSUM_EN.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              s_valid,
    input  logic [BYTE_W-1:0] s_data,
    output logic              s_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [BYTE_W-1:0] imem_wdata,
    output logic              core_hold,
    output logic              done,
    output logic              error
);

    // One extra bit so a length field of 0 can encode the full 256-byte frame.
    localparam int CNT_W = $clog2(LEN_ZERO_MEANS_MAX) + 1;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_inc;
    logic [CNT_W-1:0]   len;
    logic               take;
    logic               last;
`ifdef PROG_LOADER_CSUM_EN
    logic [BYTE_W-1:0]  sum;
`endif

    assign take      = s_valid & s_ready;
    assign count_inc = count + CNT_W'(1);
    assign last      = (count_inc == len);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE, ST_ERR: if (start) state_nxt = ST_LEN;
            ST_LEN:                   if (take)  state_nxt = ST_DATA;
            ST_DATA: begin
                if (take && last) begin
`ifdef PROG_LOADER_CSUM_EN
                    state_nxt = ST_CSUM;
`else
                    state_nxt = ST_DONE;
`endif
                end
            end
`ifdef PROG_LOADER_CSUM_EN
            ST_CSUM: if (take) state_nxt = (s_data == sum) ? ST_DONE : ST_ERR;
`endif
            default:                  state_nxt = ST_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they change with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            s_ready    <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            core_hold  <= 1'b1;
            done       <= 1'b0;
            count      <= '0;
            len        <= '0;
        end else begin
            state     <= state_nxt;
            s_ready   <= (state_nxt == ST_LEN) || (state_nxt == ST_DATA) || (state_nxt == ST_CSUM);
            done      <= (state_nxt == ST_DONE);
            core_hold <= (state_nxt != ST_DONE);
            imem_we   <= (state == ST_DATA) && take;
            if (state == ST_LEN && take) begin
                len   <= (s_data == '0) ? CNT_W'(LEN_ZERO_MEANS_MAX) : CNT_W'(s_data);
                count <= '0;
            end
            if (state == ST_DATA && take) begin
                imem_addr  <= ADDR_W'(BASE_ADDR) + ADDR_W'(count);
                imem_wdata <= s_data;
                count      <= count_inc;
            end
        end
    end

`ifdef PROG_LOADER_CSUM_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum   <= '0;
            error <= 1'b0;
        end else begin
            error <= (state_nxt == ST_ERR);
            if (state == ST_LEN && take)
                sum <= '0;
            else if (state == ST_DATA && take)
                sum <= sum + s_data;
        end
    end
`else
    assign error = 1'b0;
`endif

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writer side of the instruction-memory interface.
- Accepts a framed byte stream on a valid/ready handshake and writes the bytes into instruction memory at consecutive addresses.
- Holds the processor core in reset while loading and releases it only after a good load.
- Sits between the host/serial front end and the instruction memory write port, alongside the eight-bit processor top.

Parameters:
- ADDR_W, 8, instruction memory address width; memory depth is 2^ADDR_W.
- BASE_ADDR, 0, address of the first loaded byte.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  single-cycle pulse; begins a load from IDLE, DONE or ERR
- s_valid  input  1  stream byte valid
- s_data  input  8  stream byte
- s_ready  output  1  loader can accept a byte this cycle
- imem_we  output  1  instruction memory write enable, one-cycle pulse per byte
- imem_addr  output  ADDR_W  instruction memory write address
- imem_wdata  output  8  instruction memory write data
- core_hold  output  1  reset request to the processor; 1 = core held
- done  output  1  load completed and accepted
- error  output  1  load failed checksum

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high.
- Reset values: state IDLE, s_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_hold=1, done=0, error=0. Internal count, len and sum clear to 0.
- Handshake: a byte is consumed only when s_valid and s_ready are both 1 on a rising edge. s_valid while s_ready=0 has no effect.
- States: IDLE, LEN, DATA, CSUM, DONE, ERR. Outputs are registered.
- IDLE: s_ready=0. On start, go to LEN, with core_hold=1, done=0, error=0.
- LEN: s_ready=1. The consumed byte is the length N; N=0 means 256 bytes. Clear count and sum, then go to DATA.
- DATA: s_ready=1. For each consumed byte b:
  - next cycle, imem_we=1, imem_addr=(BASE_ADDR+count) mod 2^ADDR_W, imem_wdata=b;
  - sum=(sum+b) mod 256; count increments.
  - When the consumed byte is the N-th, go to CSUM, or to DONE if the feature is out.
  - Write latency is exactly 1 cycle after the handshake. imem_we is 0 in every other cycle.
  - Back-to-back bytes give back-to-back write pulses.
- CSUM: s_ready=1. The consumed byte is compared with sum. Equal goes to DONE; unequal goes to ERR.
- DONE: s_ready=0, done=1, core_hold=0. Hold until start, then go to LEN with core_hold=1 and done=0 in the next cycle.
- ERR: s_ready=0, error=1, core_hold=1. start goes to LEN and clears error.
- start in LEN, DATA or CSUM is ignored. It never aborts a load in progress.
- Address wrap: if BASE_ADDR+N exceeds 2^ADDR_W, addresses wrap modulo 2^ADDR_W with no error.
- Reset during a load: immediate return to reset values. Bytes already written stay in memory. core_hold stays 1.
- imem_addr and imem_wdata hold their last written values when imem_we=0.

Optional Feature:
- Macro PROG_LOADER_CSUM_EN.
- Defined: the CSUM state exists; a trailing checksum byte (8-bit sum of data bytes mod 256) is required; a mismatch enters ERR.
- Undefined: no CSUM state and no sum register. DATA goes straight to DONE after the N-th byte. error is tied to 0.

Decomposition:
- Shared package prog_loader_pkg holds:
  - state enum type (IDLE, LEN, DATA, CSUM, DONE, ERR);
  - LEN_ZERO_MEANS_MAX constant (256);
  - byte width constant 8.
- No sub-module is needed. The checksum accumulator is an 8-bit register inside the FSM, so the block stays a single module.

Test Plan:
- Reset asserted mid-cycle, asynchronously -> all outputs immediately at reset values; core_hold=1.
- start; stream 03, A1, B2, C3, checksum 16 (A1+B2+C3 mod 256 = 0x16) -> writes (00,A1), (01,B2), (02,C3), each 1 cycle after its handshake; then done=1, core_hold=0.
- Same load with checksum 17 -> three writes occur, then error=1, done=0, core_hold=1. A new start then returns to LEN with error=0.
- s_valid toggled 1/0 every cycle during DATA, plus one start pulse mid-DATA -> only valid cycles produce writes; the start is ignored; addresses stay contiguous.
- BASE_ADDR=FE, length 04 -> writes at FE, FF, 00, 01; with the checksum correct, done=1.
- Reset asserted after 2 of 5 data bytes, then a fresh load of length 01 -> load completes normally at BASE_ADDR; no stale count or sum carried over.
